logic_eval_pipe: RTL and testbench

//  Parametrised, pipelined successor of the team's 1-bit x/y logic function block.
//  - Evaluates the x/y function set bitwise over WIDTH-bit vectors, with a run-time mode select.
//  - 2-stage elastic pipeline with valid/ready handshake on both sides.
//  - Sits between a stimulus/data source and a downstream consumer in the DSD lab datapath.

---
 rtl/logic_eval_pipe.sv | 148 ++++++++++++++
 tb/tb_logic_eval_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_eval_pipe.sv
// Two-stage elastic pipeline evaluating the x/y logic function set bitwise over WIDTH-bit operands.
// Optional statistics counters are built only when the STATS_EN macro is defined.
module logic_eval_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned X1_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [X1_W-1:0]  x_ones
);

  logic             s1_v_q, s2_v_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q;
  logic [1:0]       s1_mode_q;
  logic [WIDTH-1:0] s2_x_q, s2_y_q;
  logic [WIDTH-1:0] f_x, f_y;
  logic             s1_rdy, s2_rdy;

  // Backward ready path is purely combinational so a full pipe still moves every cycle.
  assign s2_rdy   = ~s2_v_q | out_ready;
  assign s1_rdy   = ~s1_v_q | s2_rdy;
  assign in_ready = s1_rdy;

  always_comb begin
    f_x = '0;
    f_y = '0;
    unique case (s1_mode_q)
      2'b00: begin
        f_x = ~s1_c_q ^ (s1_a_q | s1_b_q);
        f_y = s1_a_q & s1_b_q;
      end
      2'b01: begin
        f_x = s1_c_q ^ (s1_a_q | s1_b_q);
        f_y = s1_a_q & s1_b_q;
      end
      2'b10: begin
        f_x = ~s1_c_q ^ (s1_a_q & s1_b_q);
        f_y = s1_a_q | s1_b_q;
      end
      2'b11: begin
        f_x = s1_a_q;
        f_y = s1_b_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_c_q    <= '0;
      s1_mode_q <= '0;
    end else if (s1_rdy) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= a;
        s1_b_q    <= b;
        s1_c_q    <= c;
        s1_mode_q <= mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      s2_x_q <= '0;
      s2_y_q <= '0;
    end else if (s2_rdy) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_x_q <= f_x;
        s2_y_q <= f_y;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign x         = s2_x_q;
  assign y         = s2_y_q;

`ifdef STATS_EN
  localparam int unsigned PopW = $clog2(WIDTH + 1);
  localparam int unsigned SumW = ((X1_W > PopW) ? X1_W : PopW) + 1;

  logic             out_fire;
  logic [PopW-1:0]  x_pop;
  logic [SumW-1:0]  ones_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X1_W-1:0]  ones_q, ones_d;

  assign out_fire = s2_v_q & out_ready;

  always_comb begin
    x_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      x_pop = x_pop + PopW'(s2_x_q[i]);
    end
    ones_sum = SumW'(ones_q) + SumW'(x_pop);
  end

  // Clear takes priority over a coincident transfer; that transfer is dropped from the stats.
  always_comb begin
    cnt_d  = cnt_q;
    ones_d = ones_q;
    if (stats_clr) begin
      cnt_d  = '0;
      ones_d = '0;
    end else if (out_fire) begin
      cnt_d  = cnt_q + CNT_W'(1);
      ones_d = ((ones_sum >> X1_W) != '0) ? '1 : X1_W'(ones_sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ones_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ones_q <= ones_d;
    end
  end

  assign txn_cnt = cnt_q;
  assign x_ones  = ones_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign txn_cnt          = '0;
  assign x_ones           = '0;
`endif

endmodule

// File: tb/tb_logic_eval_pipe.sv
// Randomised and directed bench for logic_eval_pipe against a queue-based reference model.
// Stats checks expect zeros unless STATS_EN is defined.
module tb_logic_eval_pipe;

`ifdef STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, stats_clr;
  logic [7:0]  a, b, c, x, y;
  logic [1:0]  mode;
  logic [15:0] txn_cnt;
  logic [3:0]  x_ones;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  int m_txn = 0;
  int m_ones = 0;

  logic_eval_pipe #(.WIDTH(8), .CNT_W(16), .X1_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .y(y), .stats_clr(stats_clr), .txn_cnt(txn_cnt), .x_ones(x_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_fn(logic [7:0] ma, logic [7:0] mb, logic [7:0] mc,
                                           logic [1:0] mm);
    case (mm)
      2'd0:    return {~mc ^ (ma | mb), ma & mb};
      2'd1:    return {mc ^ (ma | mb), ma & mb};
      2'd2:    return {~mc ^ (ma & mb), ma | mb};
      default: return {ma, mb};
    endcase
  endfunction

  // One clock: sample handshakes before the edge, then advance the reference model.
  task automatic tick(output bit ifire, output bit ofire, output logic [15:0] got,
                      output logic [15:0] want);
    logic [15:0] beat;
    bit clr;
    @(negedge clk);
    ifire = in_valid && in_ready;
    ofire = out_valid && out_ready;
    got   = {x, y};
    beat  = model_fn(a, b, c, mode);
    clr   = stats_clr;
    @(posedge clk);
    #1;
    if (ifire) exp_q.push_back(beat);
    want = 16'h0;
    if (ofire) want = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
    if (clr) begin
      m_txn  = 0;
      m_ones = 0;
    end else if (ofire) begin
      m_txn  = (m_txn + 1) % 65536;
      m_ones = m_ones + $countones(want[15:8]);
      if (m_ones > 15) m_ones = 15;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stats_clr = 1'b0;
    a = '0; b = '0; c = '0; mode = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_txn = 0;
    m_ones = 0;
  endtask

  task automatic test_reset();
    bit fi, fo;
    logic [15:0] g, w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stats_clr = 1'b0;
    a = '0; b = '0; c = '0; mode = '0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || x !== 8'h00 || y !== 8'h00 || txn_cnt !== 16'h0 ||
        x_ones !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got ov=%b x=%h y=%h cnt=%h ones=%h ir=%b want 0 00 00 0 0 1",
               out_valid, x, y, txn_cnt, x_ones, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); m_txn = 0; m_ones = 0;
    in_valid = 1'b1; a = 8'h5A; b = 8'h3C; c = 8'h0F; mode = 2'd1;
    repeat (3) tick(fi, fo, g, w);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill: got out_valid=%b want 1", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || x !== 8'h00 || y !== 8'h00 || txn_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: got ov=%b x=%h y=%h cnt=%h want 0 00 00 0",
               out_valid, x, y, txn_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); m_txn = 0; m_ones = 0;
  endtask

  task automatic test_modes();
    logic [15:0] vec_exp [4] = '{16'hA9C0, 16'h56C0, 16'h95FC, 16'hF0CC};
    bit fi, fo;
    logic [15:0] g, w;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 8'hF0; b = 8'hCC; c = 8'hAA; mode = 2'(i);
      tick(fi, fo, g, w);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mode%0d_latency1: got out_valid=%b want 0", i, out_valid);
      end
      tick(fi, fo, g, w);
      checks++;
      if (out_valid !== 1'b1 || {x, y} !== vec_exp[i]) begin
        errors++;
        $display("FAIL mode%0d_result: got ov=%b xy=%h want 1 %h", i, out_valid, {x, y},
                 vec_exp[i]);
      end
      tick(fi, fo, g, w);
      checks++;
      if (!fo || g !== w) begin
        errors++;
        $display("FAIL mode%0d_scoreboard: got fire=%b xy=%h want 1 %h", i, fo, g, w);
      end
      if (i == 0) begin
        checks++;
        if (txn_cnt !== (StatsEn ? 16'd1 : 16'd0) || x_ones !== (StatsEn ? 4'd4 : 4'd0)) begin
          errors++;
          $display("FAIL mode0_stats: got cnt=%0d ones=%0d want %0d %0d", txn_cnt, x_ones,
                   StatsEn ? 1 : 0, StatsEn ? 4 : 0);
        end
      end
    end
  endtask

  task automatic test_saturation();
    bit fi, fo;
    logic [15:0] g, w;
    apply_reset();
    out_ready = 1'b1; a = 8'hFF; b = 8'h00; c = 8'hFF; mode = 2'd0;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 2);
      tick(fi, fo, g, w);
      if (fo) begin
        checks++;
        if (g !== 16'hFF00 || g !== w) begin
          errors++;
          $display("FAIL sat_out: got %h want ff00 (model %h)", g, w);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (txn_cnt !== (StatsEn ? 16'd2 : 16'd0) || x_ones !== (StatsEn ? 4'd15 : 4'd0)) begin
      errors++;
      $display("FAIL sat_stats: got cnt=%0d ones=%0d want %0d %0d", txn_cnt, x_ones,
               StatsEn ? 2 : 0, StatsEn ? 15 : 0);
    end
  endtask

  task automatic test_stall();
    logic [7:0]  ba [6], bb [6], bc [6];
    logic [1:0]  bm [6];
    logic [15:0] first;
    bit fi, fo;
    logic [15:0] g, w;
    int idx = 0;
    int nout = 0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      ba[i] = 8'($urandom); bb[i] = 8'($urandom); bc[i] = 8'($urandom); bm[i] = 2'($urandom);
    end
    first = model_fn(ba[0], bb[0], bc[0], bm[0]);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; a = ba[idx]; b = bb[idx]; c = bc[idx]; mode = bm[idx];
      tick(fi, fo, g, w);
      if (fi) idx++;
      if (k >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || {x, y} !== first || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold%0d: got ov=%b xy=%h ir=%b want 1 %h 0", k, out_valid,
                   {x, y}, in_ready, first);
        end
      end
    end
    checks++;
    if (idx != 2) begin
      errors++;
      $display("FAIL stall_accepted: got %0d want 2", idx);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 40 && nout < 6; k++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        a = ba[idx]; b = bb[idx]; c = bc[idx]; mode = bm[idx];
      end
      tick(fi, fo, g, w);
      if (fi) idx++;
      if (fo) begin
        checks++;
        if (g !== w || g !== model_fn(ba[nout], bb[nout], bc[nout], bm[nout])) begin
          errors++;
          $display("FAIL stall_order%0d: got %h want %h", nout, g,
                   model_fn(ba[nout], bb[nout], bc[nout], bm[nout]));
        end
        nout++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 6) begin
      errors++;
      $display("FAIL stall_drain: got %0d results want 6", nout);
    end
  endtask

  task automatic test_stats_clr();
    bit fi, fo;
    logic [15:0] g, w;
    out_ready = 1'b1; in_valid = 1'b1;
    a = 8'h0F; b = 8'h11; c = 8'h22; mode = 2'd2;
    tick(fi, fo, g, w);
    in_valid = 1'b0;
    tick(fi, fo, g, w);
    stats_clr = 1'b1;
    tick(fi, fo, g, w);
    stats_clr = 1'b0;
    checks++;
    if (!fo || g !== w || txn_cnt !== 16'd0 || x_ones !== 4'd0) begin
      errors++;
      $display("FAIL stats_clr: got fire=%b xy=%h cnt=%0d ones=%0d want 1 %h 0 0", fo, g, w,
               txn_cnt, x_ones);
    end
    in_valid = 1'b1;
    tick(fi, fo, g, w);
    in_valid = 1'b0;
    repeat (2) tick(fi, fo, g, w);
    checks++;
    if (txn_cnt !== (StatsEn ? 16'(m_txn) : 16'd0) || x_ones !== (StatsEn ? 4'(m_ones) : 4'd0))
    begin
      errors++;
      $display("FAIL stats_after_clr: got cnt=%0d ones=%0d want %0d %0d", txn_cnt, x_ones,
               StatsEn ? m_txn : 0, StatsEn ? m_ones : 0);
    end
  endtask

  task automatic test_random();
    bit fi, fo;
    logic [15:0] g, w;
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      stats_clr = ($urandom_range(31) == 0);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); mode = 2'($urandom);
      tick(fi, fo, g, w);
      if (fo) begin
        checks++;
        if (g !== w) begin
          errors++;
          $display("FAIL rand_out%0d: got %h want %h", k, g, w);
        end
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        checks++;
        if ({x, y} !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_head%0d: got %h want %h", k, {x, y}, exp_q[0]);
        end
      end
      checks++;
      if (txn_cnt !== (StatsEn ? 16'(m_txn) : 16'd0) ||
          x_ones !== (StatsEn ? 4'(m_ones) : 4'd0)) begin
        errors++;
        $display("FAIL rand_stats%0d: got cnt=%0d ones=%0d want %0d %0d", k, txn_cnt, x_ones,
                 StatsEn ? m_txn : 0, StatsEn ? m_ones : 0);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; stats_clr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(fi, fo, g, w);
      if (fo) begin
        checks++;
        if (g !== w) begin
          errors++;
          $display("FAIL rand_drain%0d: got %h want %h", k, g, w);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_lost: got %0d pending ov=%b want 0 0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_saturation();
    test_stall();
    test_stats_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
